// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode hazard unit: N-operand forwarding, load-use stall, multi-cycle scoreboard
module hazard_scoreboard #(
  parameter int NUM_SRC = 3,
  parameter int REG_AW  = 5,
  parameter int LAT_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   ID_Src,
  input  logic [NUM_SRC-1:0]          ID_SrcFloat,
  input  logic [NUM_SRC-1:0]          ID_SrcValid,
  input  logic [REG_AW-1:0]           EX_Dst,
  input  logic [REG_AW-1:0]           MEM_Dst,
  input  logic [REG_AW-1:0]           WB_Dst,
  input  logic                        EX_Write,
  input  logic                        MEM_Write,
  input  logic                        WB_Write,
  input  logic                        EX_Float,
  input  logic                        MEM_Float,
  input  logic                        WB_Float,
  input  logic [1:0]                  EX_WBSrc,
  input  logic                        MC_Issue,
  input  logic [REG_AW-1:0]           MC_Dst,
  input  logic                        MC_Float,
  input  logic [LAT_W-1:0]            MC_Lat,
  output logic [2*NUM_SRC-1:0]        FW,
  output logic                        stall,
  output logic                        MC_Accept,
  output logic [2*(2**REG_AW)-1:0]    busy,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int NENT = 2 * (2**REG_AW);

  // Entry index is {float, addr}: int registers low half, float high half.
  logic [NENT-1:0][LAT_W-1:0] cnt;
  logic [NENT-1:0]            busy_q;
  logic [NUM_SRC-1:0]         lu_vec;
  logic [NUM_SRC-1:0]         sb_vec;
  logic                       ex_is_load;
  logic                       waw;
  logic                       stall_raw;
  logic [REG_AW:0]            acc_idx;

  always_comb begin
    busy_q = '0;
    for (int j = 0; j < NENT; j++) begin
      busy_q[j] = (cnt[j] != '0);
    end
  end

  assign busy       = busy_q;
  assign ex_is_load = (EX_WBSrc == 2'd1) || (EX_WBSrc == 2'd2);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] src;
    logic              fl;
    logic              v;
    logic              nz;
    logic              m_ex;
    logic              m_mem;
    logic              m_wb;

    assign src = ID_Src[i*REG_AW +: REG_AW];
    assign fl  = ID_SrcFloat[i];
    assign v   = ID_SrcValid[i];
    // Integer r0 is hardwired zero; float f0 is an ordinary register.
    assign nz  = fl || (src != '0);

    assign m_ex  = v && nz && EX_Write  && (EX_Dst  == src) && (EX_Float  == fl);
    assign m_mem = v && nz && MEM_Write && (MEM_Dst == src) && (MEM_Float == fl);
    assign m_wb  = v && nz && WB_Write  && (WB_Dst  == src) && (WB_Float  == fl);

    assign FW[2*i +: 2] = !rst_n ? 2'd0 :
                          m_ex   ? 2'd1 :
                          m_mem  ? 2'd2 :
                          m_wb   ? 2'd3 : 2'd0;

    assign lu_vec[i] = m_ex && ex_is_load;
    assign sb_vec[i] = v && nz && busy_q[{fl, src}];
  end

  assign acc_idx   = {MC_Float, MC_Dst};
  assign waw       = MC_Issue && busy_q[acc_idx];
  assign stall_raw = (|lu_vec) || (|sb_vec) || waw;
  assign stall     = rst_n && stall_raw;
  assign MC_Accept = rst_n && MC_Issue && !stall_raw && (MC_Lat != '0) &&
                     !((MC_Dst == '0) && !MC_Float);

  // Accepting entry loads its latency; every other live entry counts down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int j = 0; j < NENT; j++) begin
        if (MC_Accept && (acc_idx == (REG_AW+1)'(j))) begin
          cnt[j] <= MC_Lat;
        end else if (cnt[j] != '0) begin
          cnt[j] <= cnt[j] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector and sequence bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] ID_Src;
  logic [2:0]  ID_SrcFloat, ID_SrcValid;
  logic [4:0]  EX_Dst, MEM_Dst, WB_Dst;
  logic        EX_Write, MEM_Write, WB_Write;
  logic        EX_Float, MEM_Float, WB_Float;
  logic [1:0]  EX_WBSrc;
  logic        MC_Issue;
  logic [4:0]  MC_Dst;
  logic        MC_Float;
  logic [3:0]  MC_Lat;
  logic [5:0]  FW;
  logic        stall, MC_Accept;
  logic [63:0] busy;
  logic [3:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_scoreboard #(.NUM_SRC(3), .REG_AW(5), .LAT_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Src(ID_Src), .ID_SrcFloat(ID_SrcFloat), .ID_SrcValid(ID_SrcValid),
    .EX_Dst(EX_Dst), .MEM_Dst(MEM_Dst), .WB_Dst(WB_Dst),
    .EX_Write(EX_Write), .MEM_Write(MEM_Write), .WB_Write(WB_Write),
    .EX_Float(EX_Float), .MEM_Float(MEM_Float), .WB_Float(WB_Float),
    .EX_WBSrc(EX_WBSrc),
    .MC_Issue(MC_Issue), .MC_Dst(MC_Dst), .MC_Float(MC_Float), .MC_Lat(MC_Lat),
    .FW(FW), .stall(stall), .MC_Accept(MC_Accept), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [14:0] src;
    logic [2:0]  sf, sv;
    logic [4:0]  exd;  logic exw, exf; logic [1:0] wbs;
    logic [4:0]  memd; logic memw, memf;
    logic [4:0]  wbd;  logic wbw, wbf;
    logic [5:0]  fw;
    logic        st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [14:0] src,
                              input logic [2:0] sf, input logic [2:0] sv,
                              input logic [4:0] exd, input logic exw, input logic exf,
                              input logic [1:0] wbs,
                              input logic [4:0] memd, input logic memw, input logic memf,
                              input logic [4:0] wbd, input logic wbw, input logic wbf,
                              input logic [5:0] fw, input logic st);
    vec_t v;
    v.name = name; v.src = src; v.sf = sf; v.sv = sv;
    v.exd = exd; v.exw = exw; v.exf = exf; v.wbs = wbs;
    v.memd = memd; v.memw = memw; v.memf = memf;
    v.wbd = wbd; v.wbw = wbw; v.wbf = wbf;
    v.fw = fw; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_Src = '0; ID_SrcFloat = '0; ID_SrcValid = '0;
    EX_Dst = '0; MEM_Dst = '0; WB_Dst = '0;
    EX_Write = 0; MEM_Write = 0; WB_Write = 0;
    EX_Float = 0; MEM_Float = 0; WB_Float = 0; EX_WBSrc = '0;
    MC_Issue = 0; MC_Dst = '0; MC_Float = 0; MC_Lat = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic set_reader0(input logic [4:0] a, input logic f);
    ID_Src = {10'd0, a}; ID_SrcFloat = {2'b00, f}; ID_SrcValid = 3'b001;
  endtask

  initial begin
    // op order in src literal: {op2, op1, op0}
    vecs.push_back(mk("fw_ex",         {5'd0,5'd3,5'd3}, 3'b000, 3'b111, 5'd3,1,0,2'd0, 5'd3,1,0, 5'd0,0,0, 6'b000101, 0));
    vecs.push_back(mk("fw_mem",        {5'd0,5'd3,5'd3}, 3'b000, 3'b111, 5'd3,0,0,2'd0, 5'd3,1,0, 5'd0,0,0, 6'b001010, 0));
    vecs.push_back(mk("fw_wb",         {5'd0,5'd3,5'd3}, 3'b000, 3'b111, 5'd3,0,0,2'd0, 5'd3,0,0, 5'd3,1,0, 6'b001111, 0));
    vecs.push_back(mk("r0_never",      {5'd0,5'd0,5'd0}, 3'b000, 3'b111, 5'd0,1,0,2'd1, 5'd0,1,0, 5'd0,1,0, 6'b000000, 0));
    vecs.push_back(mk("f0_normal",     {5'd0,5'd0,5'd0}, 3'b111, 3'b111, 5'd0,1,1,2'd0, 5'd0,0,0, 5'd0,0,0, 6'b010101, 0));
    vecs.push_back(mk("domain_split",  {5'd0,5'd0,5'd5}, 3'b001, 3'b001, 5'd5,1,0,2'd1, 5'd0,0,0, 5'd0,0,0, 6'b000000, 0));
    vecs.push_back(mk("domain_float",  {5'd0,5'd0,5'd5}, 3'b001, 3'b001, 5'd5,1,1,2'd1, 5'd0,0,0, 5'd0,0,0, 6'b000001, 1));
    vecs.push_back(mk("load_wbsrc2",   {5'd0,5'd7,5'd0}, 3'b000, 3'b010, 5'd7,1,0,2'd2, 5'd0,0,0, 5'd0,0,0, 6'b000100, 1));
    vecs.push_back(mk("wbsrc3_nostall",{5'd0,5'd7,5'd0}, 3'b000, 3'b010, 5'd7,1,0,2'd3, 5'd0,0,0, 5'd0,0,0, 6'b000100, 0));
    vecs.push_back(mk("invalid_ops",   {5'd3,5'd3,5'd3}, 3'b000, 3'b000, 5'd3,1,0,2'd1, 5'd3,1,0, 5'd3,1,0, 6'b000000, 0));
    vecs.push_back(mk("mixed",         {5'd9,5'd4,5'd4}, 3'b010, 3'b111, 5'd9,1,0,2'd0, 5'd4,1,0, 5'd4,1,1, 6'b011110, 0));
    vecs.push_back(mk("ex_nowrite_ld", {5'd0,5'd0,5'd8}, 3'b000, 3'b001, 5'd8,0,0,2'd1, 5'd8,1,0, 5'd0,0,0, 6'b000010, 0));
    vecs.push_back(mk("wb_domain_mis", {5'd0,5'd0,5'd6}, 3'b000, 3'b001, 5'd0,0,0,2'd0, 5'd0,0,0, 5'd6,1,1, 6'b000000, 0));

    // Reset held: outputs forced low even with matching inputs
    clear_inputs();
    rst_n = 0;
    set_reader0(5'd3, 0);
    EX_Dst = 5'd3; EX_Write = 1; EX_WBSrc = 2'd1;
    MC_Issue = 1; MC_Dst = 5'd1; MC_Lat = 4'd1;
    #3;
    check("rst_fw", FW, 0);
    check("rst_stall", stall, 0);
    check("rst_accept", MC_Accept, 0);
    tick();
    check("rst_busy", busy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    do_reset();

    foreach (vecs[k]) begin
      tick();
      ID_Src = vecs[k].src; ID_SrcFloat = vecs[k].sf; ID_SrcValid = vecs[k].sv;
      EX_Dst = vecs[k].exd; EX_Write = vecs[k].exw; EX_Float = vecs[k].exf; EX_WBSrc = vecs[k].wbs;
      MEM_Dst = vecs[k].memd; MEM_Write = vecs[k].memw; MEM_Float = vecs[k].memf;
      WB_Dst = vecs[k].wbd; WB_Write = vecs[k].wbw; WB_Float = vecs[k].wbf;
      #1;
      check({vecs[k].name, "_fw"}, FW, vecs[k].fw);
      check({vecs[k].name, "_stall"}, stall, vecs[k].st);
    end

    // Multi-cycle f2, latency 4: reader stalls exactly 4 cycles
    do_reset();
    tick();
    MC_Issue = 1; MC_Dst = 5'd2; MC_Float = 1; MC_Lat = 4'd4;
    #1;
    check("mc_accept", MC_Accept, 1);
    check("mc_issue_nostall", stall, 0);
    tick();
    MC_Issue = 0;
    set_reader0(5'd2, 1);
    #1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mc_busy_c%0d", c), busy, 64'd1 << 34);
      check($sformatf("mc_stall_c%0d", c), stall, 1);
      tick();
    end
    check("mc_busy_done", busy, 0);
    check("mc_stall_done", stall, 0);
    check("mc_stall_cnt", stall_cnt, 4);

    // WAW against busy f2
    do_reset();
    tick();
    MC_Issue = 1; MC_Dst = 5'd2; MC_Float = 1; MC_Lat = 4'd4;
    tick();
    #1;
    check("waw_accept", MC_Accept, 0);
    check("waw_stall", stall, 1);

    // Issue to f7 blocked by load-use, accepted once it clears
    do_reset();
    tick();
    set_reader0(5'd6, 0);
    EX_Dst = 5'd6; EX_Write = 1; EX_WBSrc = 2'd1;
    MC_Issue = 1; MC_Dst = 5'd7; MC_Float = 1; MC_Lat = 4'd2;
    #1;
    check("blk_stall", stall, 1);
    check("blk_accept", MC_Accept, 0);
    tick();
    EX_Write = 0;
    #1;
    check("blk_release_stall", stall, 0);
    check("blk_release_accept", MC_Accept, 1);
    tick();
    MC_Issue = 0;
    #1;
    check("blk_busy_f7", busy, 64'd1 << 39);

    // Asynchronous reset mid-countdown
    do_reset();
    tick();
    MC_Issue = 1; MC_Dst = 5'd9; MC_Float = 0; MC_Lat = 4'd9;
    #1;
    check("rmid_accept", MC_Accept, 1);
    tick();
    MC_Issue = 0;
    set_reader0(5'd9, 0);
    EX_Dst = 5'd9; EX_Write = 1; EX_WBSrc = 2'd0;
    #1;
    check("rmid_fw_pre", FW, 6'b000001);
    check("rmid_stall_pre", stall, 1);
    tick(); tick(); tick();
    check("rmid_cnt_pre", stall_cnt, 3);
    check("rmid_busy_pre", busy, 64'd1 << 9);
    #2;
    rst_n = 0;
    #1;
    check("rmid_busy", busy, 0);
    check("rmid_stall_cnt", stall_cnt, 0);
    check("rmid_fw", FW, 0);
    check("rmid_stall", stall, 0);
    do_reset();

    // Saturation of the 4-bit stall counter
    tick();
    set_reader0(5'd6, 0);
    EX_Dst = 5'd6; EX_Write = 1; EX_WBSrc = 2'd1;
    repeat (20) tick();
    check("sat_cnt", stall_cnt, 15);

    // Issue edge cases
    do_reset();
    tick();
    MC_Issue = 1; MC_Dst = 5'd0; MC_Float = 0; MC_Lat = 4'd3;
    #1;
    check("edge_r0_accept", MC_Accept, 0);
    MC_Dst = 5'd5; MC_Lat = 4'd0;
    #1;
    check("edge_lat0_accept", MC_Accept, 0);
    MC_Dst = 5'd0; MC_Float = 1; MC_Lat = 4'd1;
    #1;
    check("edge_f0_accept", MC_Accept, 1);
    tick();
    MC_Issue = 0;
    #1;
    check("edge_lat1_busy", busy, 64'd1 << 32);
    tick();
    check("edge_lat1_clear", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
